// File: rtl/dbus_pkg.sv
// Shared definitions for the CPU data-bus bridge: FSM states, access
// formats, default region bases and the region-hit helper.
package dbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DM_ACC  = 3'd1,
        S_DM_CAP  = 3'd2,
        S_IO_WAIT = 3'd3,
        S_RESP    = 3'd4
    } dbus_state_t;

    localparam logic [1:0] FMT_WORD = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_BYTE = 2'b10;

    localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h1002_0000;

    // An offset from a region base hits when its word index fits in aw bits.
    // Addresses below the base wrap to huge offsets and therefore miss.
    function automatic logic region_hit(input logic [31:0] off, input int aw);
        return (off >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dbus_lane.sv
// Byte-lane generator shared by the data RAM and MMIO paths: byte enables,
// lane-replicated store data and an alignment fault flag.
module dbus_lane
    import dbus_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    // Lane selection per format; the illegal format is folded into the fault flag.
    always_comb begin
        o_be       = 4'b0000;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_fmt)
            FMT_WORD: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            FMT_HALF: begin
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            FMT_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dbus_bridge.sv
// Data-bus bridge between the CPU load/store port and the data RAM / MMIO
// window. Decodes regions, builds byte lanes and stalls the CPU until a
// one-cycle ready (optionally with err) response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for cpu_req; decode and latch the access
// S_DM_ACC  | data RAM strobe cycle (dm_en high for exactly this cycle)
// S_DM_CAP  | capture dm_rdata for a load
// S_IO_WAIT | io_req held until io_ack or the wait timer expires
// S_RESP    | cpu_ready pulse with cpu_err
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = DEF_DATA_BASE,
    parameter int          DMEM_AW   = 11,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter int          MMIO_AW   = 8,
    parameter int          TIMEOUT   = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [1:0]         cpu_fmt,
    input  logic [31:0]        cpu_wdata,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_ready,
    output logic               cpu_err,
    output logic               dm_en,
    output logic               dm_we,
    output logic [DMEM_AW-1:0] dm_addr,
    output logic [3:0]         dm_be,
    output logic [31:0]        dm_wdata,
    input  logic [31:0]        dm_rdata,
    output logic               io_req,
    output logic               io_we,
    output logic [MMIO_AW-1:0] io_addr,
    output logic [3:0]         io_be,
    output logic [31:0]        io_wdata,
    input  logic               io_ack,
    input  logic [31:0]        io_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    dbus_state_t        r_state;
    logic               r_we;
    logic [31:0]        r_rdata;
    logic               r_ready;
    logic               r_err;
    logic [CW-1:0]      r_cnt;
    logic               r_dm_en;
    logic               r_dm_we;
    logic [DMEM_AW-1:0] r_dm_addr;
    logic [3:0]         r_dm_be;
    logic [31:0]        r_dm_wdata;
    logic               r_io_req;
    logic               r_io_we;
    logic [MMIO_AW-1:0] r_io_addr;
    logic [3:0]         r_io_be;
    logic [31:0]        r_io_wdata;

    logic [31:0] w_dm_off;
    logic [31:0] w_io_off;
    logic        w_dm_hit;
    logic        w_io_hit;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic        w_err;

    dbus_lane u_lane (
        .i_fmt      (cpu_fmt),
        .i_addr_lo  (cpu_addr[1:0]),
        .i_wdata    (cpu_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    // Region decode on the live request; the data RAM wins if regions overlap.
    always_comb begin
        w_dm_off = cpu_addr - DATA_BASE;
        w_io_off = cpu_addr - MMIO_BASE;
        w_dm_hit = region_hit(w_dm_off, DMEM_AW);
        w_io_hit = region_hit(w_io_off, MMIO_AW);
        w_err    = w_misalign | ~(w_dm_hit | w_io_hit);
    end

    // Transaction FSM with all target and CPU outputs registered.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_dm_en    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_be    <= '0;
            r_dm_wdata <= '0;
            r_io_req   <= 1'b0;
            r_io_we    <= 1'b0;
            r_io_addr  <= '0;
            r_io_be    <= '0;
            r_io_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_we <= cpu_we;
                        if (w_err) begin
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else if (w_dm_hit) begin
                            r_dm_en    <= 1'b1;
                            r_dm_we    <= cpu_we;
                            r_dm_addr  <= DMEM_AW'(w_dm_off >> 2);
                            r_dm_be    <= cpu_we ? w_be : 4'b0000;
                            r_dm_wdata <= w_wdata;
                            r_state    <= S_DM_ACC;
                        end else begin
                            r_io_req   <= 1'b1;
                            r_io_we    <= cpu_we;
                            r_io_addr  <= MMIO_AW'(w_io_off >> 2);
                            r_io_be    <= w_be;
                            r_io_wdata <= w_wdata;
                            r_cnt      <= CW'(TIMEOUT - 1);
                            r_state    <= S_IO_WAIT;
                        end
                    end
                end
                S_DM_ACC: begin
                    r_dm_en <= 1'b0;
                    r_dm_we <= 1'b0;
                    if (r_we) begin
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_DM_CAP;
                    end
                end
                S_DM_CAP: begin
                    r_rdata <= dm_rdata;
                    r_ready <= 1'b1;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_IO_WAIT: begin
                    // Ack is checked before the timer so a last-cycle ack still completes.
                    if (io_ack) begin
                        if (!r_we) begin
                            r_rdata <= io_rdata;
                        end
                        r_io_req <= 1'b0;
                        r_io_we  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_cnt == '0) begin
                        r_io_req <= 1'b0;
                        r_io_we  <= 1'b0;
                        r_ready  <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign cpu_err   = r_err;
    assign dm_en     = r_dm_en;
    assign dm_we     = r_dm_we;
    assign dm_addr   = r_dm_addr;
    assign dm_be     = r_dm_be;
    assign dm_wdata  = r_dm_wdata;
    assign io_req    = r_io_req;
    assign io_we     = r_io_we;
    assign io_addr   = r_io_addr;
    assign io_be     = r_io_be;
    assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_dbus_bridge.sv
// Self-checking bench for dbus_bridge: table of data RAM / error accesses,
// then hand-written MMIO, timeout, stray-ack and reset sequences.
module tb_dbus_bridge;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_fmt;
    logic        cpu_ready, cpu_err;
    logic        dm_en, dm_we;
    logic [10:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        io_req, io_we;
    logic [7:0]  io_addr;
    logic [3:0]  io_be;
    logic [31:0] io_wdata;
    logic        io_ack;
    logic [31:0] io_rdata;

    int n_pass = 0;
    int n_tot  = 0;
    string tag;

    logic [31:0] mem [0:2047];

    always #5 clk_in = ~clk_in;

    dbus_bridge dut (
        .clk_in(clk_in), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_fmt(cpu_fmt), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
        .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata)
    );

    // Behavioural 1-cycle-latency data RAM with byte enables.
    always @(posedge clk_in) begin
        if (dm_en) begin
            if (dm_we) begin
                for (int b = 0; b < 4; b++)
                    if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
            end else begin
                dm_rdata <= mem[dm_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  fmt;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_rdy;
        logic        exp_dm_en;
        logic [10:0] exp_dm_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", tag, nm, act, exp);
    endtask

    task automatic run_dm(input vec_t v);
        int rc = 0, en_cnt = 0, en_cyc = 0;
        logic got_err = 1'b0, io_seen = 1'b0, s_we = 1'b0;
        logic [10:0] s_a = '0;
        logic [3:0]  s_be = '0;
        logic [31:0] s_wd = '0, rd = '0;
        @(negedge clk_in);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
        cpu_fmt = v.fmt; cpu_wdata = v.wdata;
        for (int c = 1; c <= 8 && rc == 0; c++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (dm_en) begin
                if (en_cnt == 0) begin
                    en_cyc = c; s_a = dm_addr; s_be = dm_be; s_wd = dm_wdata; s_we = dm_we;
                end
                en_cnt++;
            end
            if (io_req) io_seen = 1'b1;
            if (cpu_ready) begin
                rc = c; got_err = cpu_err; rd = cpu_rdata; cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("ready_cycle", rc, v.exp_rdy);
        chk("err", got_err, v.exp_err);
        chk("dm_en_cycles", en_cnt, v.exp_dm_en ? 1 : 0);
        chk("io_req_quiet", io_seen, 1'b0);
        chk("rdata", rd, v.exp_rdata);
        if (v.exp_dm_en) begin
            chk("dm_en_cycle", en_cyc, 1);
            chk("dm_addr", s_a, v.exp_dm_addr);
            chk("dm_we", s_we, v.we);
            chk("dm_be", s_be, v.exp_be);
            if (v.we) chk("dm_wdata", s_wd, v.exp_wdata);
        end
        @(negedge clk_in);
        chk("ready_pulse", cpu_ready, 1'b0);
    endtask

    task automatic run_io(input logic we, input logic [31:0] addr, input logic [1:0] fmt,
                          input logic [31:0] wd, input int ack_cyc, input logic [31:0] ack_data,
                          output int rc, output logic err, output int req_cnt,
                          output logic [7:0] ia, output logic iwe, output logic [3:0] ibe,
                          output logic [31:0] iwd, output logic [31:0] rd, output logic unstable);
        rc = 0; err = 1'b0; req_cnt = 0; ia = '0; iwe = 1'b0; ibe = '0; iwd = '0;
        rd = '0; unstable = 1'b0;
        io_rdata = ack_data;
        @(negedge clk_in);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_fmt = fmt; cpu_wdata = wd;
        for (int c = 1; c <= 40 && rc == 0; c++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (io_req) begin
                if (req_cnt == 0) begin
                    ia = io_addr; iwe = io_we; ibe = io_be; iwd = io_wdata;
                end else if (ia !== io_addr || iwe !== io_we || ibe !== io_be || iwd !== io_wdata) begin
                    unstable = 1'b1;
                end
                req_cnt++;
            end
            if (dm_en) unstable = 1'b1;
            if (cpu_ready) begin
                rc = c; err = cpu_err; rd = cpu_rdata; cpu_req = 1'b0;
            end
            io_ack = (c == ack_cyc);
        end
        io_ack = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        int rc, rq;
        logic er, iwe, unst, seen;
        logic [7:0]  ia;
        logic [3:0]  ibe;
        logic [31:0] iwd, rd;
        vec_t sw0;

        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        dm_rdata = 32'h0;
        //          we    addr           fmt    wdata         err   rdy en    dmaddr  be       wdata         rdata
        vecs[0]  = '{1'b1, 32'h1001_0008, 2'b00, 32'hDEADBEEF, 1'b0, 2, 1'b1, 11'd2,   4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 32'h1001_0003, 2'b10, 32'h000000A5, 1'b0, 2, 1'b1, 11'd0,   4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{1'b0, 32'h1001_0000, 2'b00, 32'h0,        1'b0, 3, 1'b1, 11'd0,   4'b0000, 32'h0,        32'hA5000000};
        vecs[3]  = '{1'b1, 32'h1001_0006, 2'b01, 32'h00001234, 1'b0, 2, 1'b1, 11'd1,   4'b1100, 32'h12341234, 32'hA5000000};
        vecs[4]  = '{1'b0, 32'h1001_0004, 2'b00, 32'h0,        1'b0, 3, 1'b1, 11'd1,   4'b0000, 32'h0,        32'h12340000};
        vecs[5]  = '{1'b1, 32'h1001_0009, 2'b10, 32'h0000007F, 1'b0, 2, 1'b1, 11'd2,   4'b0010, 32'h7F7F7F7F, 32'h12340000};
        vecs[6]  = '{1'b0, 32'h1001_0008, 2'b00, 32'h0,        1'b0, 3, 1'b1, 11'd2,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[7]  = '{1'b0, 32'h1001_0001, 2'b01, 32'h0,        1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[8]  = '{1'b0, 32'h1000_0000, 2'b00, 32'h0,        1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[9]  = '{1'b0, 32'h1001_0000, 2'b11, 32'h0,        1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[10] = '{1'b1, 32'h1001_0002, 2'b00, 32'h12345678, 1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[11] = '{1'b0, 32'h1001_1FFC, 2'b00, 32'h0,        1'b0, 3, 1'b1, 11'h7FF, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h1001_2000, 2'b00, 32'h0,        1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 32'h1001_000A, 2'b01, 32'h0,        1'b0, 3, 1'b1, 11'd2,   4'b0000, 32'h0,        32'hDEAD7FEF};
        vecs[14] = '{1'b0, 32'h1002_0400, 2'b00, 32'h0,        1'b1, 1, 1'b0, 11'd0,   4'b0000, 32'h0,        32'hDEAD7FEF};

        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_fmt = '0;
        cpu_wdata = '0; io_ack = 1'b0; io_rdata = '0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        tag = "reset";
        chk("cpu_outs", {cpu_ready, cpu_err, 30'd0} | cpu_rdata, 32'h0);
        chk("dm_ctl", {dm_en, dm_we, dm_be, dm_addr}, 32'h0);
        chk("dm_wdata", dm_wdata, 32'h0);
        chk("io_ctl", {io_req, io_we, io_be, io_addr}, 32'h0);
        chk("io_wdata", io_wdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            tag = $sformatf("vec%0d", i);
            run_dm(vecs[i]);
        end

        tag = "io_wr_ack3";
        run_io(1'b1, 32'h1002_0004, 2'b00, 32'h11223344, 3, 32'h0, rc, er, rq, ia, iwe, ibe, iwd, rd, unst);
        chk("ready_cycle", rc, 4); chk("err", er, 1'b0); chk("req_cycles", rq, 3);
        chk("io_addr", ia, 8'd1); chk("io_we", iwe, 1'b1); chk("io_be", ibe, 4'b1111);
        chk("io_wdata", iwd, 32'h11223344); chk("stable", unst, 1'b0); chk("rdata", rd, 32'hDEAD7FEF);

        tag = "io_rd_timeout";
        run_io(1'b0, 32'h1002_0010, 2'b00, 32'h0, 0, 32'hBAD0BAD0, rc, er, rq, ia, iwe, ibe, iwd, rd, unst);
        chk("ready_cycle", rc, 17); chk("err", er, 1'b1); chk("req_cycles", rq, 16);
        chk("io_addr", ia, 8'd4); chk("io_we", iwe, 1'b0); chk("stable", unst, 1'b0);
        chk("rdata", rd, 32'hDEAD7FEF);

        tag = "io_rd_ack16";
        run_io(1'b0, 32'h1002_0010, 2'b00, 32'h0, 16, 32'hCAFEF00D, rc, er, rq, ia, iwe, ibe, iwd, rd, unst);
        chk("ready_cycle", rc, 17); chk("err", er, 1'b0); chk("req_cycles", rq, 16);
        chk("rdata", rd, 32'hCAFEF00D);

        tag = "io_sb_ack1";
        run_io(1'b1, 32'h1002_0003, 2'b10, 32'h0000005A, 1, 32'h0, rc, er, rq, ia, iwe, ibe, iwd, rd, unst);
        chk("ready_cycle", rc, 2); chk("err", er, 1'b0); chk("req_cycles", rq, 1);
        chk("io_addr", ia, 8'd0); chk("io_be", ibe, 4'b1000); chk("io_wdata", iwd, 32'h5A5A5A5A);

        tag = "stray_ack";
        seen = 1'b0;
        @(negedge clk_in);
        io_ack = 1'b1; io_rdata = 32'h11111111;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (cpu_ready || io_req) seen = 1'b1;
        end
        io_ack = 1'b0;
        chk("no_response", seen, 1'b0);
        chk("rdata_held", cpu_rdata, 32'hCAFEF00D);

        tag = "reset_mid_io";
        @(negedge clk_in);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1002_0008; cpu_fmt = 2'b00;
        @(posedge clk_in); @(negedge clk_in);
        chk("io_req_c1", io_req, 1'b1);
        @(posedge clk_in); @(negedge clk_in);
        chk("io_req_c2", io_req, 1'b1);
        reset = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        chk("io_req_after", io_req, 1'b0);
        chk("ready_after", cpu_ready, 1'b0);
        chk("rdata_cleared", cpu_rdata, 32'h0);
        reset = 1'b0; cpu_req = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in); @(negedge clk_in);
            if (cpu_ready || io_req) seen = 1'b1;
        end
        chk("no_late_ready", seen, 1'b0);

        tag = "sw_after_reset";
        sw0 = '{1'b1, 32'h1001_0000, 2'b00, 32'hAABBCCDD, 1'b0, 2, 1'b1, 11'd0, 4'b1111, 32'hAABBCCDD, 32'h0};
        run_dm(sw0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
